ysyx_220053_ifq: RTL and testbench
==================================

# ysyx_220053_ifq

Instruction fetch queue between the fetch unit (IFU) and the decode unit (IDU). Captures each valid {pc, instr} pair the IFU produces, buffers up to DEPTH entries in program order, and presents them to the IDU through a valid/ready handshake. This decouples IFU stalls (icache misses) from IDU stalls. A single-cycle flush on branch/jump redirect discards everything in flight.

## Interface
- DEPTH, 4, number of entries; power of two, >= 2
- PW, 64, pc width
- IW, 32, instruction width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset; 0 clears all state immediately
- in_valid  in  1  IFU has a fetched instruction this cycle
- in_pc  in  PW  pc of the incoming instruction
- in_instr  in  IW  incoming instruction word
- in_ready  out  1  queue accepts a push this cycle (= !full)
- out_valid  out  1  head entry is valid (= !empty)
- out_pc  out  PW  pc of head entry
- out_instr  out  IW  instruction of head entry
- out_misalign  out  1  head entry pc[1:0] != 0
- out_ready  in  1  IDU consumes head this cycle
- flush  in  1  redirect: discard all entries and the same-cycle push
- count  out  log2(DEPTH)+1  number of valid entries

## Operation
- Storage: DEPTH entries of {misalign, pc, instr}; write pointer wp, read pointer rp, each log2(DEPTH) bits, wrapping modulo DEPTH; occupancy counter cnt, 0..DEPTH.
- push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
- push: entry[wp] <= {in_pc[1:0]!=0, in_pc, in_instr}; wp <= wp+1.
- pop: rp <= rp+1.
- cnt <= cnt + push - pop; simultaneous push and pop leave cnt unchanged.
- full = (cnt == DEPTH); empty = (cnt == 0). in_ready = !full and is independent of out_ready: no push when full, even with a same-cycle pop.
- Outputs out_pc/out_instr/out_misalign are read combinationally from entry[rp]. Their value when out_valid=0 is don't-care, except after reset, when it is 0.
- flush (highest priority): wp <= 0, rp <= 0, cnt <= 0 next edge. push and pop are suppressed in that cycle. Entry contents are not cleared.
- No pass-through: an instruction pushed in cycle N is visible at out_* in cycle N+1 at the earliest.
- Reset (rst=0, any time, including mid-burst): wp=rp=cnt=0 and all entries cleared to 0, asynchronously. Resulting outputs: out_valid=0, in_ready=1, count=0, out_pc=0, out_instr=0, out_misalign=0.

## Timing
- Push-to-output latency: 1 cycle when empty.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < cnt < DEPTH.
- in_ready and out_valid depend only on registered cnt. There is no combinational path from out_ready to in_ready, or from in_valid to out_valid.
- flush asserted in cycle N: out_valid=0 and in_ready=1 in cycle N+1. A push in N+1 appears at the output in N+2.
- The wrap of wp/rp from DEPTH-1 to 0 needs no special handling; ordering is preserved across the wrap.
- Release of rst is sampled synchronously to clk. The first push is accepted on the first rising edge with rst=1.

## Test plan
- Reset mid-operation: fill 3 entries, pull rst low between edges -> out_valid=0, count=0, in_ready=1 at once with no clock edge; out_pc=0.
- Single pass: push {0x80000000, 0x00000413} with out_ready=0 -> next cycle out_valid=1, out_pc=0x80000000, out_instr=0x00000413, count=1. Pop -> count=0, out_valid=0.
- Full/backpressure: out_ready=0, push pcs 0x80000000..0x8000000C -> count=4, in_ready=0. A fifth push (0x80000010) is dropped. Pops then return the four pcs in order.
- Wrap and streaming: in_valid=out_ready=1 for 20 cycles with pc incrementing by 4 -> outputs match inputs in order with 1-cycle lag, count stays 1, no drops across the pointer wrap.
- Flush with simultaneous push/pop: count=2, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0. The flushed-cycle push never appears.
- Misalign: push pc 0x80000002 -> out_misalign=1 when it is at head. Push 0x80000004 -> out_misalign=0.

Source files
------------

// File: rtl/ysyx_220053_ifq.sv
// Instruction fetch queue: buffers {pc, instr} pairs from IFU to IDU in program order.
// Head is read combinationally from storage; a redirect flush empties the queue in one cycle.
module ysyx_220053_ifq #(
  parameter int DEPTH = 4,
  parameter int PW    = 64,
  parameter int IW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [PW-1:0]              in_pc,
  input  logic [IW-1:0]              in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [PW-1:0]              out_pc,
  output logic [IW-1:0]              out_instr,
  output logic                       out_misalign,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic          misalign;
    logic [PW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;

  logic   w_full;
  logic   w_empty;
  logic   w_push;
  logic   w_pop;
  entry_t w_head;

  // in_ready/out_valid come from the registered count only, so no same-cycle pop frees a slot.
  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = in_valid & ~w_full & ~flush;
  assign w_pop   = ~w_empty & out_ready & ~flush;
  assign w_head  = r_mem[r_rp];

  assign in_ready     = ~w_full;
  assign out_valid    = ~w_empty;
  assign out_pc       = w_head.pc;
  assign out_instr    = w_head.instr;
  assign out_misalign = w_head.misalign;
  assign count        = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= '{misalign: (in_pc[1:0] != 2'b00), pc: in_pc, instr: in_instr};
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_ysyx_220053_ifq.sv
// Bench for the instruction fetch queue: vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_ysyx_220053_ifq;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  ysyx_220053_ifq #(.DEPTH(DEPTH), .PW(64), .IW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_misalign(out_misalign), .out_ready(out_ready),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mis;
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t model_q[$];

  typedef struct {
    bit          v;
    logic [63:0] pc;
    logic [31:0] ins;
    bit          ordy;
    bit          fl;
    bit          e_vld;
    int          e_cnt;
    bit          e_rdy;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    bit          e_mis;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("m_out_valid", 64'(out_valid), 64'(model_q.size() > 0));
    chk("m_in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
    chk("m_count", 64'(count), 64'(model_q.size()));
    if (model_q.size() > 0) begin
      chk("m_out_pc", out_pc, model_q[0].pc);
      chk("m_out_instr", 64'(out_instr), 64'(model_q[0].ins));
      chk("m_out_misalign", 64'(out_misalign), 64'(model_q[0].mis));
    end
  endtask

  // Apply one cycle of inputs at posedge+1, check against model, clock, update model.
  task automatic drive(input bit v, input logic [63:0] pc, input logic [31:0] ins,
                       input bit ordy, input bit fl);
    bit   do_push;
    bit   do_pop;
    ent_t e;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    #1;
    model_check();
    do_push = v && (model_q.size() < DEPTH) && !fl;
    do_pop  = (model_q.size() > 0) && ordy && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop) model_q.delete(0);
      if (do_push) begin
        e.mis = (pc[1:0] != 2'b00);
        e.pc  = pc;
        e.ins = ins;
        model_q.push_back(e);
      end
    end
  endtask

  vec_t vecs[$];

  task automatic add(input bit v, input logic [63:0] pc, input logic [31:0] ins,
                     input bit ordy, input bit fl, input bit e_vld, input int e_cnt,
                     input bit e_rdy, input logic [63:0] e_pc, input logic [31:0] e_ins,
                     input bit e_mis);
    vec_t t;
    t.v = v; t.pc = pc; t.ins = ins; t.ordy = ordy; t.fl = fl;
    t.e_vld = e_vld; t.e_cnt = e_cnt; t.e_rdy = e_rdy;
    t.e_pc = e_pc; t.e_ins = e_ins; t.e_mis = e_mis;
    vecs.push_back(t);
  endtask

  initial begin
    // Reset state from power-up, no clock edge needed.
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_misalign", 64'(out_misalign), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single pass
    add(1, 64'h80000000, 32'h00000413, 0, 0, 1, 1, 1, 64'h80000000, 32'h00000413, 0);
    add(0, 64'h0,        32'h0,        1, 0, 0, 0, 1, 64'h0,        32'h0,        0);
    // Fill to full, drop the fifth push, no push on pop-while-full
    add(1, 64'h80000000, 32'h11111111, 0, 0, 1, 1, 1, 64'h80000000, 32'h11111111, 0);
    add(1, 64'h80000004, 32'h22222222, 0, 0, 1, 2, 1, 64'h80000000, 32'h11111111, 0);
    add(1, 64'h80000008, 32'h33333333, 0, 0, 1, 3, 1, 64'h80000000, 32'h11111111, 0);
    add(1, 64'h8000000C, 32'h44444444, 0, 0, 1, 4, 0, 64'h80000000, 32'h11111111, 0);
    add(1, 64'h80000010, 32'h55555555, 0, 0, 1, 4, 0, 64'h80000000, 32'h11111111, 0);
    add(1, 64'h80000014, 32'h66666666, 1, 0, 1, 3, 1, 64'h80000004, 32'h22222222, 0);
    add(0, 64'h0,        32'h0,        1, 0, 1, 2, 1, 64'h80000008, 32'h33333333, 0);
    add(0, 64'h0,        32'h0,        1, 0, 1, 1, 1, 64'h8000000C, 32'h44444444, 0);
    add(0, 64'h0,        32'h0,        1, 0, 0, 0, 1, 64'h0,        32'h0,        0);
    // Misalign
    add(1, 64'h80000002, 32'hAAAA0001, 0, 0, 1, 1, 1, 64'h80000002, 32'hAAAA0001, 1);
    add(1, 64'h80000004, 32'hAAAA0002, 1, 0, 1, 1, 1, 64'h80000004, 32'hAAAA0002, 0);
    add(0, 64'h0,        32'h0,        1, 0, 0, 0, 1, 64'h0,        32'h0,        0);
    // Flush with simultaneous push and pop
    add(1, 64'h800000A0, 32'hBBBB0001, 0, 0, 1, 1, 1, 64'h800000A0, 32'hBBBB0001, 0);
    add(1, 64'h800000A4, 32'hBBBB0002, 0, 0, 1, 2, 1, 64'h800000A0, 32'hBBBB0001, 0);
    add(1, 64'h800000A8, 32'hBBBB0003, 1, 1, 0, 0, 1, 64'h0,        32'h0,        0);
    add(1, 64'h800000B0, 32'hBBBB0004, 0, 0, 1, 1, 1, 64'h800000B0, 32'hBBBB0004, 0);
    add(0, 64'h0,        32'h0,        1, 0, 0, 0, 1, 64'h0,        32'h0,        0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].ins, vecs[i].ordy, vecs[i].fl);
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_vld));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
      if (vecs[i].e_vld) begin
        chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_out_instr", i), 64'(out_instr), 64'(vecs[i].e_ins));
        chk($sformatf("v%0d_out_misalign", i), 64'(out_misalign), 64'(vecs[i].e_mis));
      end
    end

    // Streaming across the pointer wrap: one-cycle lag, count stays 1
    for (int i = 0; i < 20; i++) begin
      drive(1, 64'h80001000 + 64'(4 * i), 32'h00C00000 + 32'(i), 1, 0);
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_out_pc", out_pc, 64'h80001000 + 64'(4 * i));
      chk("stream_out_instr", 64'(out_instr), 64'(32'h00C00000 + 32'(i)));
    end
    drive(0, 64'h0, 32'h0, 1, 0);
    chk("stream_drain_count", 64'(count), 64'd0);

    // Reset mid-operation, observed before any clock edge
    for (int i = 0; i < 3; i++) drive(1, 64'h80002000 + 64'(4 * i), 32'hD0 + 32'(i), 0, 0);
    chk("pre_rst_count", 64'(count), 64'd3);
    in_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_out_pc", out_pc, 64'd0);
    chk("mrst_out_instr", 64'(out_instr), 64'd0);
    model_q.delete();
    @(posedge clk);
    #1;
    chk("mrst_hold_count", 64'(count), 64'd0);
    rst = 1'b1;
    drive(1, 64'h80003000, 32'h00000113, 0, 0);
    chk("post_rst_push_count", 64'(count), 64'd1);
    chk("post_rst_push_pc", out_pc, 64'h80003000);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [63:0] rpc;
      rpc = {32'h8000_0000, $urandom};
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      drive($urandom_range(0, 3) != 0, rpc, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    model_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
